// File: rtl/multi_core_lock_arbiter.sv
// Round-robin mutual-exclusion arbiter for N cores sharing the lock memory.
// Hold-until-release grant with a watchdog that forces release after MAX_HOLD cycles.
module multi_core_lock_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned HOLD_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] need_lock,
    input  logic [NUM_CORES-1:0] release_lock,
    output logic [NUM_CORES-1:0] grant,
    output logic [NUM_CORES-1:0] lock,
    output logic [IDX_W-1:0]     owner,
    output logic                 busy,
    output logic [HOLD_W-1:0]    hold_cnt,
    output logic                 timeout_evt
);

    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [NUM_CORES-1:0] grant_d;
    logic [IDX_W-1:0]     owner_d;
    logic                 busy_d;
    logic [HOLD_W-1:0]    hold_cnt_d;
    logic                 timeout_evt_d;

    logic [2*NUM_CORES-1:0] req_dbl;
    logic [NUM_CORES-1:0]   req_rot;
    logic                   found;
    logic [IDX_W-1:0]       sel;
    logic [SUM_W-1:0]       sel_sum;
    logic [SUM_W-1:0]       next_sum;
    logic [IDX_W-1:0]       owner_next;
    logic                   owner_rel;
    logic                   owner_req;
    logic                   wd_hit;
    logic                   rel_hit;

    // Rotate requests so bit 0 is rr_ptr, then take the first set bit.
    always_comb begin
        req_dbl = {need_lock, need_lock} >> rr_ptr;
        req_rot = req_dbl[NUM_CORES-1:0];
        found   = 1'b0;
        sel     = '0;
        sel_sum = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                sel_sum = SUM_W'(rr_ptr) + SUM_W'(i);
                if (sel_sum >= SUM_W'(NUM_CORES)) begin
                    sel_sum = sel_sum - SUM_W'(NUM_CORES);
                end
                sel = sel_sum[IDX_W-1:0];
            end
        end
    end

    // Release conditions for the current owner; watchdog only when nothing else releases.
    always_comb begin
        owner_rel = release_lock[owner];
        owner_req = need_lock[owner];
        wd_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT) && !owner_rel && owner_req;
        rel_hit   = owner_rel || !owner_req || wd_hit;
        next_sum  = SUM_W'(owner) + SUM_W'(1);
        if (next_sum >= SUM_W'(NUM_CORES)) begin
            next_sum = '0;
        end
        owner_next = next_sum[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (found) state_d = HELD;
            HELD: if (rel_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = '0;
        owner_d       = '0;
        busy_d        = 1'b0;
        hold_cnt_d    = '0;
        timeout_evt_d = 1'b0;
        rr_ptr_d      = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_d = NUM_CORES'(1) << sel;
                    owner_d = sel;
                    busy_d  = 1'b1;
                end
            end
            HELD: begin
                if (rel_hit) begin
                    rr_ptr_d      = owner_next;
                    timeout_evt_d = wd_hit;
                end else begin
                    grant_d    = grant;
                    owner_d    = owner;
                    busy_d     = 1'b1;
                    hold_cnt_d = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
            timeout_evt <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            grant       <= grant_d;
            owner       <= owner_d;
            busy        <= busy_d;
            hold_cnt    <= hold_cnt_d;
            timeout_evt <= timeout_evt_d;
            rr_ptr      <= rr_ptr_d;
        end
    end

    // Every core other than the owner stalls while the lock is held.
    assign lock = {NUM_CORES{busy}} & ~grant;

endmodule

// File: tb/tb_multi_core_lock_arbiter.sv
// Directed self-checking bench for multi_core_lock_arbiter (4 cores, MAX_HOLD=16).
module tb_multi_core_lock_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] need_lock;
    logic [3:0] release_lock;
    logic [3:0] grant;
    logic [3:0] lock;
    logic [1:0] owner;
    logic       busy;
    logic [4:0] hold_cnt;
    logic       timeout_evt;

    int checks;
    int errors;

    multi_core_lock_arbiter #(
        .NUM_CORES(4),
        .IDX_W    (2),
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .need_lock   (need_lock),
        .release_lock(release_lock),
        .grant       (grant),
        .lock        (lock),
        .owner       (owner),
        .busy        (busy),
        .hold_cnt    (hold_cnt),
        .timeout_evt (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        need_lock = '0;
        release_lock = '0;
        step();
        rst = 1'b0;
    endtask

    // Grant must be zero or one-hot on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($onehot0(grant) === 1'b1) else begin
                errors++;
                $error("FAIL onehot: observed %b expected zero-or-one-hot", grant);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        need_lock = '0;
        release_lock = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_lock", 32'(lock), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hold", 32'(hold_cnt), 32'h0);
        chk("rst_tevt", 32'(timeout_evt), 32'h0);
        step();
        rst = 1'b0;

        // 1: single request, release pulse, rr_ptr advances to 3
        need_lock = 4'b0100;
        step();
        chk("t1_grant", 32'(grant), 32'h4);
        chk("t1_owner", 32'(owner), 32'h2);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_lock", 32'(lock), 32'hB);
        chk("t1_hold0", 32'(hold_cnt), 32'h0);
        step(); step(); step();
        chk("t1_hold3", 32'(hold_cnt), 32'h3);
        release_lock = 4'b0100;
        step();
        release_lock = '0;
        chk("t1_rel_grant", 32'(grant), 32'h0);
        chk("t1_rel_lock", 32'(lock), 32'h0);
        chk("t1_rel_busy", 32'(busy), 32'h0);
        need_lock = 4'b0101;
        step();
        chk("t1_rr_grant", 32'(grant), 32'h1);
        chk("t1_rr_owner", 32'(owner), 32'h0);

        // 2: all four request, each owner releases after 2 cycles
        do_reset();
        need_lock = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            chk("t2_owner", 32'(owner), 32'(k % 4));
            chk("t2_lock", 32'(lock), 32'(~(4'b0001 << (k % 4)) & 4'hF));
            step();
            chk("t2_hold1", 32'(hold_cnt), 32'h1);
            release_lock = 4'b0001 << (k % 4);
            step();
            release_lock = '0;
            chk("t2_idle_grant", 32'(grant), 32'h0);
            chk("t2_idle_busy", 32'(busy), 32'h0);
        end

        // 3: watchdog forces core 1 off after 16 cycles, core 3 is next
        do_reset();
        need_lock = 4'b0010;
        step();
        chk("t3_grant", 32'(grant), 32'h2);
        need_lock = 4'b1010;
        for (int k = 0; k < 15; k++) step();
        chk("t3_hold15", 32'(hold_cnt), 32'hF);
        chk("t3_still_grant", 32'(grant), 32'h2);
        chk("t3_no_tevt", 32'(timeout_evt), 32'h0);
        step();
        chk("t3_wd_grant", 32'(grant), 32'h0);
        chk("t3_wd_tevt", 32'(timeout_evt), 32'h1);
        chk("t3_wd_hold", 32'(hold_cnt), 32'h0);
        step();
        chk("t3_tevt_pulse", 32'(timeout_evt), 32'h0);
        chk("t3_next_grant", 32'(grant), 32'h8);
        chk("t3_next_owner", 32'(owner), 32'h3);

        // 4: owner 3 drops need_lock without release
        need_lock = 4'b0010;
        step();
        chk("t4_drop_grant", 32'(grant), 32'h0);
        chk("t4_drop_tevt", 32'(timeout_evt), 32'h0);
        step();
        chk("t4_regrant", 32'(grant), 32'h2);
        need_lock = '0;
        step();
        chk("t4_final", 32'(grant), 32'h0);

        // 5: non-owner release is ignored
        do_reset();
        need_lock = 4'b0001;
        step();
        chk("t5_grant", 32'(grant), 32'h1);
        release_lock = 4'b0010;
        need_lock = 4'b0011;
        step();
        chk("t5_keep_grant", 32'(grant), 32'h1);
        chk("t5_hold1", 32'(hold_cnt), 32'h1);
        step();
        release_lock = '0;
        chk("t5_hold2", 32'(hold_cnt), 32'h2);
        chk("t5_lock", 32'(lock), 32'hE);

        // 6: asynchronous reset mid-hold
        do_reset();
        need_lock = 4'b1000;
        step();
        chk("t6_grant", 32'(grant), 32'h8);
        for (int k = 0; k < 7; k++) step();
        chk("t6_hold7", 32'(hold_cnt), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'h0);
        chk("t6_async_lock", 32'(lock), 32'h0);
        chk("t6_async_owner", 32'(owner), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_hold", 32'(hold_cnt), 32'h0);
        step();
        rst = 1'b0;
        need_lock = 4'b1001;
        step();
        chk("t6_post_grant", 32'(grant), 32'h1);
        chk("t6_post_owner", 32'(owner), 32'h0);

        need_lock = '0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
